// File: rtl/alarm_buzzer_if.sv
// Signal bundle between the alarm buzzer and its controller: the alarm enable,
// the stop button, the current and alarm time fields, and the buzzer outputs.
interface alarm_buzzer_if;
  logic       i_alarm_en;
  logic       i_stop;
  logic [5:0] i_hour;
  logic [5:0] i_min;
  logic [5:0] i_sec;
  logic [5:0] i_alarm_hour;
  logic [5:0] i_alarm_min;
  logic [5:0] i_alarm_sec;
  logic       o_buzz;
  logic       o_ringing;

  modport master (
    output i_alarm_en, i_stop, i_hour, i_min, i_sec,
           i_alarm_hour, i_alarm_min, i_alarm_sec,
    input  o_buzz, o_ringing
  );

  modport slave (
    input  i_alarm_en, i_stop, i_hour, i_min, i_sec,
           i_alarm_hour, i_alarm_min, i_alarm_sec,
    output o_buzz, o_ringing
  );
endinterface

// File: rtl/alarm_buzzer.sv
// Alarm buzzer: rings a three-tone-plus-rest melody on the rising edge of a
// time/alarm match, until stopped, disabled, or the ring timeout expires.
module alarm_buzzer #(
  parameter logic [31:0] NOTE_CYC   = 32'd12500000,
  parameter logic [31:0] TONE0_HALF = 32'd47778,
  parameter logic [31:0] TONE1_HALF = 32'd37922,
  parameter logic [31:0] TONE2_HALF = 32'd31888,
  parameter logic [31:0] RING_CYC   = 32'd3000000000
) (
  input  logic          clk,
  input  logic          rst,
  alarm_buzzer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, RING, HOLD} state_e;

  state_e      state_q;
  logic        match_q;
  logic        stop_q;
  logic [31:0] ring_cnt_q;
  logic [31:0] note_cnt_q;
  logic [31:0] tone_cnt_q;
  logic [1:0]  step_q;
  logic        buzz_q;
  logic        ringing_q;

  logic        match;
  logic        match_rise;
  logic        stop_rise;
  logic [31:0] tone_half;

  assign match = (bus.i_hour == bus.i_alarm_hour) &
                 (bus.i_min  == bus.i_alarm_min)  &
                 (bus.i_sec  == bus.i_alarm_sec);

  assign match_rise = match & ~match_q;
  assign stop_rise  = bus.i_stop & ~stop_q;

  always_comb begin
    tone_half = TONE0_HALF;
    case (step_q)
      2'd0:    tone_half = TONE0_HALF;
      2'd1:    tone_half = TONE1_HALF;
      2'd2:    tone_half = TONE2_HALF;
      default: tone_half = TONE0_HALF;
    endcase
  end

  // Counters are only live in RING; every exit from RING zeroes them and the buzzer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      match_q    <= 1'b0;
      stop_q     <= 1'b0;
      ring_cnt_q <= 32'd0;
      note_cnt_q <= 32'd0;
      tone_cnt_q <= 32'd0;
      step_q     <= 2'd0;
      buzz_q     <= 1'b0;
      ringing_q  <= 1'b0;
    end else begin
      match_q <= match;
      stop_q  <= bus.i_stop;
      case (state_q)
        IDLE: begin
          if (bus.i_alarm_en) state_q <= ARMED;
        end
        ARMED: begin
          if (!bus.i_alarm_en) begin
            state_q <= IDLE;
          end else if (match_rise) begin
            state_q    <= RING;
            ringing_q  <= 1'b1;
            ring_cnt_q <= 32'd0;
            note_cnt_q <= 32'd0;
            tone_cnt_q <= 32'd0;
            step_q     <= 2'd0;
            buzz_q     <= 1'b0;
          end
        end
        RING: begin
          if (!bus.i_alarm_en || stop_rise || (ring_cnt_q == RING_CYC - 32'd1)) begin
            state_q    <= bus.i_alarm_en ? HOLD : IDLE;
            ringing_q  <= 1'b0;
            ring_cnt_q <= 32'd0;
            note_cnt_q <= 32'd0;
            tone_cnt_q <= 32'd0;
            step_q     <= 2'd0;
            buzz_q     <= 1'b0;
          end else begin
            ring_cnt_q <= ring_cnt_q + 32'd1;
            if (note_cnt_q == NOTE_CYC - 32'd1) begin
              note_cnt_q <= 32'd0;
              tone_cnt_q <= 32'd0;
              buzz_q     <= 1'b0;
              step_q     <= step_q + 2'd1;
            end else begin
              note_cnt_q <= note_cnt_q + 32'd1;
              if (step_q == 2'd3) begin
                tone_cnt_q <= 32'd0;
                buzz_q     <= 1'b0;
              end else if (tone_cnt_q >= tone_half - 32'd1) begin
                tone_cnt_q <= 32'd0;
                buzz_q     <= ~buzz_q;
              end else begin
                tone_cnt_q <= tone_cnt_q + 32'd1;
              end
            end
          end
        end
        HOLD: begin
          // Waiting for the match to clear keeps the same second from ringing twice.
          if (!bus.i_alarm_en) begin
            state_q <= IDLE;
          end else if (!match) begin
            state_q <= ARMED;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_buzz    = buzz_q;
  assign bus.o_ringing = ringing_q;

endmodule
